conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_win_counter.sv | 51 +++++
 rtl/conv_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution address sequencer.
// Optional stall input is enabled by defining CONV_SEQ_STALL_EN.
package conv_pkg;

  localparam int ADDR_W = 16;
  localparam int KSEL_W = 4;
  localparam int RC_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int win_count(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/conv_win_counter.sv
// Raster counter over all 3x3 window origins; imAddr built by
// incrementing (+1 per column, +3 on row wrap) instead of a multiply.
module conv_win_counter
  import conv_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              step,
  output logic              last
);

  localparam logic [RC_W-1:0] COL_MAX = RC_W'(IMG_W - 3);
  localparam logic [RC_W-1:0] ROW_MAX = RC_W'(IMG_H - 3);

  logic [RC_W-1:0] row_q;
  logic [RC_W-1:0] col_q;
  logic            eol;

  assign eol  = (col_q == COL_MAX);
  assign last = eol && (row_q == ROW_MAX);
  // the final window holds so the address never runs past the frame
  assign step = en && !last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
      addr  <= '0;
    end else if (clr) begin
      row_q <= '0;
      col_q <= '0;
      addr  <= '0;
    end else if (step) begin
      if (eol) begin
        col_q <= '0;
        row_q <= row_q + RC_W'(1);
        addr  <= addr + ADDR_W'(3);
      end else begin
        col_q <= col_q + RC_W'(1);
        addr  <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Full-frame 3x3 convolution address sequencer (IDLE/SCAN/DRAIN/DONE).
// Define CONV_SEQ_STALL_EN to add a stall input that freezes a pass.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CONV_SEQ_STALL_EN
  input  logic              stall,
`endif
  input  logic              start,
  input  logic [KSEL_W-1:0] ksel,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] imAddr,
  output logic [ADDR_W-1:0] kAddr,
  output logic [ADDR_W-1:0] filtimAddr,
  output logic              wr_en
);

  localparam int NWIN = win_count(IMG_W, IMG_H);
  localparam logic [2:0] DLAST =
    3'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_t            state_q;
  state_t            state_d;
  logic              run;
  logic              accept;
  logic              scan_vld;
  logic              win_en;
  logic              win_step;
  logic              win_last;
  logic [2:0]        dcnt;
  logic [ADDR_W-1:0] oidx;
  logic [KSEL_W-1:0] kreg;

`ifdef CONV_SEQ_STALL_EN
  assign run = !stall;
`else
  assign run = 1'b1;
`endif

  assign accept   = (state_q == IDLE) && start;
  assign scan_vld = (state_q == SCAN);
  assign win_en   = scan_vld && run;
  assign kAddr    = ADDR_W'(kreg);

  conv_win_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_win (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (win_en),
    .addr (imAddr),
    .step (win_step),
    .last (win_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stall only matters once a pass is running; IDLE always accepts start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (run && win_last)
          state_d = (LATENCY == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (run && dcnt == DLAST) state_d = DONE;
      end
      DONE: begin
        if (run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      IDLE: ;
      SCAN,
      DRAIN: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kreg <= '0;
    end else if (accept) begin
      kreg <= ksel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt <= '0;
    end else if (state_q != DRAIN) begin
      dcnt <= '0;
    end else if (run) begin
      dcnt <= dcnt + 3'd1;
    end
  end

  // output pixel index; parks at NWIN-1 after the final window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oidx <= '0;
    end else if (accept) begin
      oidx <= '0;
    end else if (win_step && oidx != ADDR_W'(NWIN - 1)) begin
      oidx <= oidx + ADDR_W'(1);
    end
  end

  if (LATENCY == 0) begin : g_nodly
    assign wr_en      = scan_vld && run;
    assign filtimAddr = oidx;
  end else begin : g_dly
    logic [LATENCY-1:0] vld_d;
    logic [ADDR_W-1:0]  idx_d [LATENCY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_d <= '0;
        for (int i = 0; i < LATENCY; i++) idx_d[i] <= '0;
      end else if (run) begin
        vld_d[0] <= scan_vld;
        idx_d[0] <= oidx;
        for (int i = 1; i < LATENCY; i++) begin
          vld_d[i] <= vld_d[i-1];
          idx_d[i] <= idx_d[i-1];
        end
      end
    end

    assign wr_en      = vld_d[LATENCY-1] && run;
    assign filtimAddr = idx_d[LATENCY-1];
  end

endmodule
